alu_host_sequencer: RTL

Bus-side master for the radix-4/SRT-2 ALU: accepts an operation request on a valid/ready port, drives the ALU's `BEGIN`/`op_code`/`inbus` load sequence, waits for `END`, and collects the result bytes from `outbus`. It returns one 16-bit response per request and flags a timeout. It sits between the testbench or system controller and the `alu` top, on the opposite side of the ALU's 8-bit operand/result bus.

---
 rtl/alu_host_sequencer_pkg.sv | 31 +++
 rtl/alu_host_sequencer_if.sv | 42 ++++
 rtl/alu_host_sequencer_timer.sv | 34 +++
 rtl/alu_host_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_host_sequencer_pkg.sv
// Shared definitions for the ALU host sequencer.
// ALU op-code encoding, sequencer state encoding, and the per-op counts of
// operand bytes loaded on inbus and result bytes returned on outbus.
package alu_bus_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_WAIT_END,
    ST_RESPOND
  } seq_state_e;

  // Operand bytes driven in LOAD: x, y (and z for divide).
  function automatic logic [1:0] operand_bytes(input alu_op_e op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

  // Result bytes expected on outbus while waiting for END.
  function automatic logic [1:0] result_bytes(input alu_op_e op);
    return ((op == OP_MUL) || (op == OP_DIV)) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/alu_host_sequencer_if.sv
// Bus bundle between the host sequencer, its requester and the ALU.
// Request side : req_valid/req_ready handshake with op and operand bytes.
// ALU side     : alu_begin, alu_op_code, alu_inbus out; alu_outbus, alu_end in.
// Response side: rsp_valid/rsp_ready handshake with rsp_data and rsp_timeout.
// modport master: the sequencer. modport slave: the environment around it.
interface alu_host_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic [7:0]  req_z;

  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_end;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    input  req_valid, req_op, req_x, req_y, req_z,
    input  alu_outbus, alu_end,
    input  rsp_ready,
    output req_ready,
    output alu_begin, alu_op_code, alu_inbus,
    output rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, req_z,
    output alu_outbus, alu_end,
    output rsp_ready,
    input  req_ready,
    input  alu_begin, alu_op_code, alu_inbus,
    input  rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/alu_host_sequencer_timer.sv
// WAIT_END watchdog for the ALU host sequencer.
// Ports: clk, reset (async active-low), clr (synchronous clear, wins over en),
//        en (count this cycle), expired (this enabled cycle is the
//        TIMEOUT_CYCLES-th since the last clear).
module alu_host_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Flags the cycle whose increment takes the count to TIMEOUT_CYCLES, so the
  // abort lands exactly TIMEOUT_CYCLES cycles after entering WAIT_END.
  assign expired = en && !clr && (count_q == TC_LAST);

endmodule

// File: rtl/alu_host_sequencer.sv
// Bus-side master for the radix-4/SRT-2 ALU.
// Accepts one request (op, x, y, z), pulses alu_begin, loads the operand
// bytes on alu_inbus, collects 1 or 2 result bytes from alu_outbus while
// alu_end is high, and returns a 16-bit response (or a timeout abort).
// Ports: clk, reset (async active-low), bus (alu_host_sequencer_if.master).
// Every bus output is driven straight from a register.
module alu_host_sequencer
  import alu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_host_sequencer_if.master  bus
);

  seq_state_e  state_q, state_d;
  alu_op_e     op_q, op_d;
  logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  cap_q, cap_d;
  logic [7:0]  hi_q, hi_d;

  logic        req_ready_q, req_ready_d;
  logic        begin_q, begin_d;
  logic [1:0]  opc_q, opc_d;
  logic [7:0]  inbus_q, inbus_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  logic        timer_en;
  logic        timer_clr;
  logic        timer_expired;

  assign timer_en  = (state_q == ST_WAIT_END);
  assign timer_clr = !timer_en;

  alu_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    x_d           = x_q;
    y_d           = y_q;
    z_d           = z_q;
    idx_d         = idx_q;
    cap_d         = cap_q;
    hi_d          = hi_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    begin_d       = 1'b0;
    inbus_d       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d    = alu_op_e'(bus.req_op);
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          z_d     = bus.req_z;
          begin_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        idx_d   = 2'd0;
        inbus_d = x_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // inbus already shows byte idx_q; stage the following byte or stop.
        if (idx_q == operand_bytes(op_q) - 2'd1) begin
          cap_d   = 2'd0;
          state_d = ST_WAIT_END;
        end else begin
          idx_d   = idx_q + 2'd1;
          inbus_d = (idx_q == 2'd0) ? y_q : z_q;
        end
      end
      ST_WAIT_END: begin
        if (timer_expired) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESPOND;
        end else if (bus.alu_end) begin
          if (cap_q + 2'd1 == result_bytes(op_q)) begin
            if (result_bytes(op_q) == 2'd1)
              rsp_data_d = {{8{bus.alu_outbus[7]}}, bus.alu_outbus};
            else
              rsp_data_d = {hi_q, bus.alu_outbus};
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESPOND;
          end else begin
            hi_d  = bus.alu_outbus;
            cap_d = cap_q + 2'd1;
          end
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESPOND);
    opc_d       = (state_d == ST_IDLE) ? 2'b00 : op_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      idx_q         <= '0;
      cap_q         <= '0;
      hi_q          <= '0;
      req_ready_q   <= 1'b1;
      begin_q       <= 1'b0;
      opc_q         <= '0;
      inbus_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      idx_q         <= idx_d;
      cap_q         <= cap_d;
      hi_q          <= hi_d;
      req_ready_q   <= req_ready_d;
      begin_q       <= begin_d;
      opc_q         <= opc_d;
      inbus_q       <= inbus_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.alu_begin   = begin_q;
  assign bus.alu_op_code = opc_q;
  assign bus.alu_inbus   = inbus_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
